vga_capture: RTL and testbench

- Receive side of the 800x600 VGA link (1056x628 total, one pixel per clk).
- Samples vga_hs, vga_vs and vga_rgb and recovers the horizontal and vertical pixel positions.
- Checks the line and frame timing against the expected totals and reports lock.
- On request, captures one window of one frame into a frame-buffer RAM through a simple write port. Sits between the VGA pins and the capture RAM, for loopback test of the display path.

---
 rtl/vga_capture_if.sv | 31 +++
 rtl/vga_capture.sv | 232 +++++++++++++++++++++++
 tb/tb_vga_capture.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_capture_if.sv
// Signal bundle between the VGA pins / capture control side and the vga_capture block.
// The master drives the pins and capture request; the slave is the capture block.
interface vga_capture_if #(
    parameter int AW = 16
);
    logic          vga_hs;
    logic          vga_vs;
    logic [7:0]    vga_rgb;
    logic          cap_start;
    logic          locked;
    logic [11:0]   h_period;
    logic [11:0]   v_lines;
    logic          cap_busy;
    logic          cap_done;
    logic          cap_err;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport master (
        output vga_hs, vga_vs, vga_rgb, cap_start,
        input  locked, h_period, v_lines, cap_busy, cap_done, cap_err,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  vga_hs, vga_vs, vga_rgb, cap_start,
        output locked, h_period, v_lines, cap_busy, cap_done, cap_err,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel position from hs/vs, measures and locks to the
// line/frame timing, and captures one window of one frame into a frame-buffer write port.
module vga_capture #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 628,
    parameter int H_ACT_START = 217,
    parameter int V_ACT_START = 27,
    parameter int WIN_X       = 0,
    parameter int WIN_Y       = 0,
    parameter int WIN_W       = 80,
    parameter int WIN_H       = 60,
    parameter int AW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    vga_capture_if.slave  bus
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} lock_state_t;
    typedef enum logic [1:0] {C_IDLE, C_ARMED, C_RUN} cap_state_t;

    localparam logic [11:0]   H_TOT     = 12'(H_TOTAL);
    localparam logic [11:0]   V_TOT     = 12'(V_TOTAL);
    localparam logic [11:0]   H_LO      = 12'(H_ACT_START + WIN_X);
    localparam logic [11:0]   H_HI      = 12'(H_ACT_START + WIN_X + WIN_W - 1);
    localparam logic [11:0]   V_LO      = 12'(V_ACT_START + WIN_Y);
    localparam logic [11:0]   V_HI      = 12'(V_ACT_START + WIN_Y + WIN_H - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIN_W * WIN_H - 1);

    // ---------------------------------------------------------------- input sampling
    logic       r_s_hs, r_s_vs, r_d_hs, r_d_vs;
    logic [7:0] r_s_rgb;

    // NOTE: sequential state is always assigned with <= so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_hs  <= 1'b1;
            r_s_vs  <= 1'b1;
            r_d_hs  <= 1'b1;
            r_d_vs  <= 1'b1;
            r_s_rgb <= 8'd0;
        end else begin
            r_s_hs  <= bus.vga_hs;
            r_s_vs  <= bus.vga_vs;
            r_d_hs  <= r_s_hs;
            r_d_vs  <= r_s_vs;
            r_s_rgb <= bus.vga_rgb;
        end
    end

    logic w_hs_fall, w_vs_fall, w_frame_start;
    logic r_vs_seen;

    assign w_hs_fall     = r_d_hs & ~r_s_hs;
    assign w_vs_fall     = r_d_vs & ~r_s_vs;
    assign w_frame_start = w_hs_fall & r_vs_seen;

    // ---------------------------------------------------------------- position counters
    logic [11:0] r_h_pos, r_v_pos, r_h_period, r_v_lines;
    logic        r_h_seen, r_f_seen;
    logic [11:0] w_h_len, w_v_len;
    logic        w_h_ok, w_v_ok;

    assign w_h_len = r_h_pos + 12'd1;
    assign w_v_len = r_v_pos + 12'd1;
    assign w_h_ok  = (w_h_len == H_TOT);
    assign w_v_ok  = (w_v_len == V_TOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_pos    <= 12'd0;
            r_v_pos    <= 12'd0;
            r_vs_seen  <= 1'b0;
            r_h_seen   <= 1'b0;
            r_f_seen   <= 1'b0;
            r_h_period <= 12'd0;
            r_v_lines  <= 12'd0;
        end else begin
            if (w_hs_fall) begin
                r_h_pos  <= 12'd0;
                r_h_seen <= 1'b1;
                if (r_h_seen) r_h_period <= w_h_len;
                if (r_vs_seen) begin
                    r_v_pos  <= 12'd0;
                    r_f_seen <= 1'b1;
                    if (r_f_seen) r_v_lines <= w_v_len;
                end else if (r_v_pos != 12'hFFF) begin
                    r_v_pos <= w_v_len;
                end
            end else if (r_h_pos != 12'hFFF) begin
                r_h_pos <= w_h_len;
            end
            // A vs fall coinciding with an hs fall is kept pending for the next hs fall.
            if (w_vs_fall)          r_vs_seen <= 1'b1;
            else if (w_frame_start) r_vs_seen <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- lock FSM
    lock_state_t r_lock_state, w_lock_next;
    logic [1:0]  r_good, w_good_next;
    logic        r_bad, w_bad_next;
    logic        w_locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_state <= SEARCH;
            r_good       <= 2'd0;
            r_bad        <= 1'b0;
        end else begin
            r_lock_state <= w_lock_next;
            r_good       <= w_good_next;
            r_bad        <= w_bad_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_lock_next = r_lock_state;
        w_good_next = r_good;
        w_bad_next  = r_bad;
        case (r_lock_state)
            SEARCH: begin
                if (w_frame_start) begin
                    w_lock_next = MEASURE;
                    w_good_next = 2'd0;
                    w_bad_next  = 1'b0;
                end
            end
            MEASURE: begin
                if (w_hs_fall && !w_h_ok) w_bad_next = 1'b1;
                if (w_frame_start) begin
                    w_bad_next = 1'b0;
                    // The line ending on this hs fall belongs to the frame being judged.
                    if (!r_bad && w_h_ok && w_v_ok) begin
                        w_good_next = r_good + 2'd1;
                        if (r_good == 2'd1) w_lock_next = LOCKED;
                    end else begin
                        w_good_next = 2'd0;
                    end
                end
            end
            LOCKED: begin
                if ((w_hs_fall && !w_h_ok) || (w_frame_start && !w_v_ok))
                    w_lock_next = SEARCH;
            end
            default: w_lock_next = SEARCH;
        endcase
    end

    assign w_locked = (r_lock_state == LOCKED);

    // ---------------------------------------------------------------- capture FSM
    cap_state_t    r_cap_state, w_cap_next;
    logic          w_in_win, w_wr_fire, w_done_evt, w_abort, w_addr_clr;
    logic          r_wr_en, r_cap_done, r_cap_err;
    logic [AW-1:0] r_addr, r_wr_addr;
    logic [7:0]    r_wr_data;

    assign w_in_win = (r_h_pos >= H_LO) && (r_h_pos <= H_HI) &&
                      (r_v_pos >= V_LO) && (r_v_pos <= V_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cap_state <= C_IDLE;
        else     r_cap_state <= w_cap_next;
    end

    always_comb begin
        w_cap_next = r_cap_state;
        w_wr_fire  = 1'b0;
        w_done_evt = 1'b0;
        w_abort    = 1'b0;
        w_addr_clr = 1'b0;
        case (r_cap_state)
            C_IDLE: begin
                if (bus.cap_start) w_cap_next = C_ARMED;
            end
            C_ARMED: begin
                if (w_frame_start && w_locked) begin
                    w_cap_next = C_RUN;
                    w_addr_clr = 1'b1;
                end
            end
            C_RUN: begin
                if (!w_locked) begin
                    w_abort    = 1'b1;
                    w_cap_next = C_IDLE;
                end else if (r_wr_en && (r_wr_addr == LAST_ADDR)) begin
                    w_done_evt = 1'b1;
                    w_cap_next = C_IDLE;
                end else begin
                    w_wr_fire = w_in_win;
                end
            end
            default: w_cap_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
            r_addr     <= '0;
            r_cap_done <= 1'b0;
            r_cap_err  <= 1'b0;
        end else begin
            r_wr_en    <= w_wr_fire;
            r_cap_done <= w_done_evt;
            r_cap_err  <= w_abort;
            if (w_addr_clr) begin
                r_addr <= '0;
            end else if (w_wr_fire) begin
                r_addr    <= r_addr + AW'(1);
                r_wr_addr <= r_addr;
                r_wr_data <= r_s_rgb;
            end
        end
    end

    assign bus.locked   = w_locked;
    assign bus.h_period = r_h_period;
    assign bus.v_lines  = r_v_lines;
    assign bus.cap_busy = (r_cap_state != C_IDLE);
    assign bus.cap_done = r_cap_done;
    assign bus.cap_err  = r_cap_err;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled 48x16 raster (8x4 window at offset 2,1)
// so that lock, capture, abort, re-arm and reset all fit in a short run.
module tb_vga_capture;

    localparam int H      = 48;
    localparam int V      = 16;
    localparam int HS_LEN = 8;
    localparam int SHORT  = 40;
    localparam int AW     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_capture_if #(.AW(AW)) u_if();

    vga_capture #(
        .H_TOTAL(H), .V_TOTAL(V), .H_ACT_START(12), .V_ACT_START(3),
        .WIN_X(2), .WIN_Y(1), .WIN_W(8), .WIN_H(4), .AW(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    // ---------------------------------------------------------------- display timing model
    // Line gl=0 carries vs low; hs is low for the first HS_LEN clocks of each line.
    // rgb = h_pos + v_pos as the receiver counts them (one clock and one line behind gx/gl).
    int gx = 0, gl = 0, gen_frame = 0, cur_len = H;
    bit gen_en = 1'b0, short_req = 1'b0, short_ack = 1'b0;

    initial begin
        u_if.vga_hs  = 1'b1;
        u_if.vga_vs  = 1'b1;
        u_if.vga_rgb = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (gen_en) begin
                if (gx == 0) begin
                    cur_len   = (short_req != short_ack) ? SHORT : H;
                    short_ack = short_req;
                end
                u_if.vga_hs  = (gx >= HS_LEN);
                u_if.vga_vs  = (gl != 0);
                u_if.vga_rgb = 8'(gx + gl - 2);
                gx++;
                if (gx == cur_len) begin
                    gx = 0;
                    if (gl == V - 1) begin
                        gl = 0;
                        gen_frame++;
                    end else begin
                        gl++;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- write-port monitor
    int          cyc = 0, n_wr = 0, n_bad = 0, n_done = 0, n_err = 0;
    int          last_wr_cyc = 0, done_cyc = 0, first_frame = -1, exp_addr = 0;
    logic [7:0]  first_data = 8'd0, last_data = 8'd0;
    logic [15:0] last_addr = 16'd0;
    logic        busy_at_done = 1'b1;

    // Window pixel a sits at h = 14 + a%8, v = 4 + a/8, so its data is 18 + a%8 + a/8.
    function automatic logic [7:0] px_at(input int a);
        return 8'(18 + (a % 8) + (a / 8));
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_addr = 0;
            end else begin
                if (u_if.wr_en) begin
                    n_wr++;
                    if (u_if.wr_addr !== 16'(exp_addr) || u_if.wr_data !== px_at(exp_addr)) n_bad++;
                    if (exp_addr == 0) begin
                        first_data  = u_if.wr_data;
                        first_frame = gen_frame;
                    end
                    last_addr   = u_if.wr_addr;
                    last_data   = u_if.wr_data;
                    last_wr_cyc = cyc;
                    exp_addr++;
                end
                if (u_if.cap_done) begin
                    n_done++;
                    done_cyc     = cyc;
                    busy_at_done = u_if.cap_busy;
                    exp_addr     = 0;
                end
                if (u_if.cap_err) begin
                    n_err++;
                    exp_addr = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- checking helpers
    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_gen(input int f, input int l, input int budget);
        for (int i = 0; i < budget && !(gen_frame == f && gl == l); i++) @(negedge clk);
    endtask

    task automatic wait_locked(input int budget, input string tag);
        for (int i = 0; i < budget && u_if.locked !== 1'b1; i++) @(negedge clk);
        check({tag, "_reached"}, 32'(u_if.locked), 32'd1);
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_wr < target; i++) @(negedge clk);
        check({tag, "_reached"}, 32'(n_wr >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_done < target; i++) @(negedge clk);
        check({tag, "_reached"}, 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_err(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_err < target; i++) @(negedge clk);
        check({tag, "_reached"}, 32'(n_err >= target), 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 u_if.cap_start = 1'b1;
        @(posedge clk); #1 u_if.cap_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"},   32'(u_if.locked),   32'd0);
        check({tag, "_h_period"}, 32'(u_if.h_period), 32'd0);
        check({tag, "_v_lines"},  32'(u_if.v_lines),  32'd0);
        check({tag, "_cap_busy"}, 32'(u_if.cap_busy), 32'd0);
        check({tag, "_cap_done"}, 32'(u_if.cap_done), 32'd0);
        check({tag, "_cap_err"},  32'(u_if.cap_err),  32'd0);
        check({tag, "_wr_en"},    32'(u_if.wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(u_if.wr_addr),  32'd0);
        check({tag, "_wr_data"},  32'(u_if.wr_data),  32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- directed sequence
    initial begin
        int base_wr, base_done, base_err, f_err, f_rst, wr_at_err;

        u_if.cap_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        @(posedge clk); #1 rst = 1'b0;
        gen_en = 1'b1;

        // Lock: frame_start at F0 line 1, good frames end at F1 and F2 line 1.
        wait_gen(2, 0, 3 * H * V);
        check("unlocked_before_second_good_frame", 32'(u_if.locked), 32'd0);
        wait_locked(2 * H, "lock");
        check("lock_frame", 32'(gen_frame), 32'd2);
        check("lock_line", 32'(gl), 32'd1);
        check("h_period_nominal", 32'(u_if.h_period), 32'd48);
        check("v_lines_nominal", 32'(u_if.v_lines), 32'd16);

        // Full capture with a second cap_start while running.
        base_wr   = n_wr;
        base_done = n_done;
        pulse_start();
        @(negedge clk);
        check("armed_busy", 32'(u_if.cap_busy), 32'd1);
        wait_wr(base_wr + 5, 2 * H * V, "cap1_progress");
        pulse_start();
        wait_done(base_done + 1, 2 * H * V, "cap1_done");
        check("cap1_writes", 32'(n_wr - base_wr), 32'd32);
        check("cap1_bad_writes", 32'(n_bad), 32'd0);
        check("cap1_first_data", 32'(first_data), 32'd18);
        check("cap1_last_data", 32'(last_data), 32'd28);
        check("cap1_last_addr", 32'(last_addr), 32'd31);
        check("cap1_frame", 32'(first_frame), 32'd3);
        check("cap1_done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd1);
        check("cap1_busy_at_done", 32'(busy_at_done), 32'd0);
        repeat (H * V) @(negedge clk);
        check("cap1_single_done", 32'(n_done - base_done), 32'd1);
        check("cap1_no_extra_writes", 32'(n_wr - base_wr), 32'd32);
        check("cap1_idle", 32'(u_if.cap_busy), 32'd0);

        // Abort: window row v=6 is driven on a 40-clock line.
        base_wr  = n_wr;
        base_err = n_err;
        pulse_start();
        wait_wr(base_wr + 10, 2 * H * V, "cap2_progress");
        short_req = ~short_req;
        wait_err(base_err + 1, 4 * H, "cap2_err");
        check("short_h_period", 32'(u_if.h_period), 32'd40);
        check("unlocked_after_short", 32'(u_if.locked), 32'd0);
        check("cap2_writes", 32'(n_wr - base_wr), 32'd24);
        check("cap2_busy_after_err", 32'(u_if.cap_busy), 32'd0);
        f_err     = gen_frame;
        wr_at_err = n_wr;
        repeat (2 * H) @(negedge clk);
        check("cap2_no_writes_after_err", 32'(n_wr - wr_at_err), 32'd0);
        check("cap2_single_err", 32'(n_err - base_err), 32'd1);

        // Arm while unlocked: waits for relock, then the following frame_start.
        pulse_start();
        @(negedge clk);
        check("arm_unlocked_busy", 32'(u_if.cap_busy), 32'd1);
        base_done = n_done;
        base_wr   = n_wr;
        wait_locked(5 * H * V, "relock");
        check("relock_frame", 32'(gen_frame - f_err), 32'd3);
        check("relock_line", 32'(gl), 32'd1);
        check("no_writes_while_unlocked", 32'(n_wr - base_wr), 32'd0);
        wait_done(base_done + 1, 2 * H * V, "cap3_done");
        check("cap3_frame", 32'(first_frame - f_err), 32'd4);
        check("cap3_writes", 32'(n_wr - base_wr), 32'd32);
        check("cap3_bad_writes", 32'(n_bad), 32'd0);
        check("cap3_done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd1);

        // Reset in the middle of a capture.
        base_wr  = n_wr;
        base_err = n_err;
        pulse_start();
        wait_wr(base_wr + 3, 2 * H * V, "cap4_progress");
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_run_reset");
        f_rst = gen_frame;
        repeat (3) @(negedge clk);
        check("reset_no_cap_err", 32'(n_err - base_err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        wait_locked(5 * H * V, "relock_after_rst");
        check("relock_after_rst_frame", 32'(gen_frame - f_rst), 32'd3);
        check("relock_after_rst_v_lines", 32'(u_if.v_lines), 32'd16);
        check("relock_after_rst_h_period", 32'(u_if.h_period), 32'd48);
        check("relock_after_rst_idle", 32'(u_if.cap_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
